// File: rtl/ex_muladd.sv
// ex_muladd: multi-cycle MULT/MULTU/MADD/MADDU(/MSUB/MSUBU) unit for the EX stage.
// Define EX_MULADD_MSUB_EN to build the MSUB/MSUBU subtract-accumulate path.
module ex_muladd (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        stallreq,
  output logic        busy,
  output logic        whilo,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;
  state_e      state_q, state_d;
  logic [63:0] prod_q, prod_d, acc_q, acc_d, res_q, res_d;
  logic [63:0] opa, opb, sum;
  logic        mac_q, mac_d, whilo_q, whilo_d, op_ok, accept;
`ifdef EX_MULADD_MSUB_EN
  logic        sub_q, sub_d;
  assign op_ok = op <= 3'd5;
  assign sum   = sub_q ? acc_q - prod_q : acc_q + prod_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sub_q <= 1'b0;
    else          sub_q <= sub_d;
  always_comb sub_d = accept ? op[2] : sub_q;
`else
  assign op_ok = !op[2];
  assign sum   = acc_q + prod_q;
`endif
  // Even ops are signed: sign-extend both operands so one 64-bit multiply serves both.
  assign opa      = {{32{~op[0] & reg1[31]}}, reg1};
  assign opb      = {{32{~op[0] & reg2[31]}}, reg2};
  assign accept   = (state_q == IDLE) && op_valid && op_ok && !flush;
  assign stallreq = accept || (state_q == MUL) || (state_q == ACC);
  assign busy     = state_q != IDLE;
  assign whilo    = whilo_q;
  assign hi       = res_q[63:32];
  assign lo       = res_q[31:0];
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    mac_d   = mac_q;
    res_d   = '0;
    whilo_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        prod_d  = opa * opb;
        acc_d   = {hi_in, lo_in};
        mac_d   = op[1] | op[2];
        state_d = MUL;
      end
      MUL: if (mac_q) state_d = ACC;
      else begin
        state_d = DONE;
        res_d   = prod_q;
        whilo_d = 1'b1;
      end
      ACC: begin
        state_d = DONE;
        res_d   = sum;
        whilo_d = 1'b1;
      end
      DONE: if (ex_stall) begin
        res_d   = res_q;
        whilo_d = 1'b1;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      res_d   = '0;
      whilo_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      prod_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      mac_q   <= 1'b0;
      whilo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      mac_q   <= mac_d;
      whilo_q <= whilo_d;
    end
endmodule
